// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I width codes,
// and the illegal-width helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths have no store form, and 011/11x are not RV32I widths.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane extraction with sign/zero extension for loads, and byte/half merging
// of store data into a previously read word.
module load_store_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shamt   = {lane, 3'b000};
    shifted = word >> shamt;
    byte_v  = shifted[7:0];
    half_v  = lane[1] ? word[31:16] : word[15:0];

    load_data = word;
    unique case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_BU:   load_data = {24'h000000, byte_v};
      F3_HU:   load_data = {16'h0000, half_v};
      default: load_data = word;
    endcase

    merge_data = wdata;
    unique case (funct3)
      F3_B:    merge_data = (word & ~(32'h000000FF << shamt))
                          | ({24'h000000, wdata[7:0]} << shamt);
      F3_H:    merge_data = lane[1] ? {wdata[15:0], word[15:0]}
                                    : {word[31:16], wdata[15:0]};
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with a word-indexed memory port. Sub-word stores are
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to report misaligned
// accesses as errors; otherwise offending low address bits are cleared.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [31:0] WORDS = 32'(MEM_WORDS);

  lsu_state_t  state, state_next;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, data_q;

  logic        misalign_h, misalign_w, out_of_range;
  logic        req_err;
  logic [31:0] addr_eff;
  logic [31:0] align_word, load_data, merge_data;

  always_comb begin
    misalign_h   = (req_funct3[1:0] == 2'b01) && req_addr[0];
    misalign_w   = (req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00);
    out_of_range = {2'b00, req_addr[31:2]} >= WORDS;
    addr_eff     = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = f3_illegal(req_we, req_funct3) || out_of_range || misalign_h || misalign_w;
`else
    req_err = f3_illegal(req_we, req_funct3) || out_of_range;
    if (misalign_h) addr_eff[0] = 1'b0;
    if (misalign_w) addr_eff[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // READ feeds the aligner straight from memory; WRITE merges into the word
  // captured during READ.
  assign align_word = (state == WRITE) ? data_q : mem_RD;

  load_store_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .word       (align_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        err_q   <= req_err;
        f3_q    <= req_funct3;
        addr_q  <= addr_eff;
        wdata_q <= req_wdata;
      end
      if (state == READ) data_q <= we_q ? mem_RD : load_data;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    mem_WE     = 1'b0;
    mem_A      = '0;
    mem_WD     = '0;
    unique case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          if (req_err)                  state_next = RESP;
          else if (!req_we)             state_next = READ;
          else if (req_funct3 == F3_W)  state_next = WRITE;
          else                          state_next = READ;
        end
      end
      READ: begin
        mem_A      = {2'b00, addr_q[31:2]};
        state_next = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_A      = {2'b00, addr_q[31:2]};
        mem_WE     = 1'b1;
        mem_WD     = (f3_q == F3_W) ? wdata_q : merge_data;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (!we_q && !err_q) ? data_q : '0;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// requests checked against an arithmetic reference model of memory.
module tb_load_store_unit;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_WE;
  logic [31:0] mem_A, mem_WD, mem_RD;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_WE     (mem_WE),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
  );

  assign mem_RD = mem[mem_A[5:0]];
  always @(posedge clk) if (mem_WE) mem[mem_A[5:0]] <= mem_WD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: size/offset arithmetic on a word array.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr_in, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err,
                                output int lat, output int we_at);
    logic [31:0] addr, w, v, mask;
    int unsigned size, off, idx;
    addr  = addr_in;
    err   = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (addr % size != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      err = 1'b1;
`else
      addr = addr - (addr % size);
`endif
    end
    idx = addr / 4;
    if (idx >= MEM_WORDS) err = 1'b1;
    rd = 32'h0; lat = 1; we_at = 0;
    if (err) return;
    off  = addr % 4;
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    w    = ref_mem[idx];
    if (!we) begin
      v = (w >> (8 * off)) & mask;
      if (f3 == 0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 1 && v[15]) v = v | 32'hFFFF_0000;
      rd  = v;
      lat = 2;
    end else begin
      ref_mem[idx] = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      lat   = (size == 4) ? 2 : 3;
      we_at = lat - 1;
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat, exp_we_at, lat, wes, we_at;
    model(we, f3, addr, wd, exp_rd, exp_err, exp_lat, exp_we_at);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    lat = 0; wes = 0; we_at = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_WE) begin wes++; we_at = lat; end
    end while (!rsp_valid && lat < 8);
    check("latency", 32'(lat), 32'(exp_lat));
    check("we_pulses", 32'(wes), (exp_we_at != 0) ? 32'd1 : 32'd0);
    check("we_cycle", 32'(we_at), 32'(exp_we_at));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", 32'(rsp_err), 32'(exp_err));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("idle_rdata", rsp_rdata, 32'd0);
    check("idle_err", 32'(rsp_err), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [2:0] f3_pool [8];
    int         n;
    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'h8899AABB;
    ref_mem[5] = 32'h8899AABB;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_we", 32'(mem_WE), 32'd0);
    check("rst_addr", mem_A, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 3'b000, 32'h16, 32'h0, 0);          // LB -> FFFFFF99
    do_req(1'b1, 3'b000, 32'h15, 32'h11, 1);         // SB -> 889911BB
    check("word5_after_sb", mem[5], 32'h889911BB);
    do_req(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 0);
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 0);
    do_req(1'b0, 3'b101, 32'h0A, 32'h0, 2);
    do_req(1'b0, 3'b010, 32'h03, 32'h0, 3);          // misaligned LW
    do_req(1'b0, 3'b011, 32'h04, 32'h0, 0);
    do_req(1'b1, 3'b010, 32'h100, 32'h12345678, 0);  // beyond MEM_WORDS
    do_req(1'b1, 3'b001, 32'h23, 32'hCAFE, 1);       // misaligned SH

    // Reset while a byte store is in WRITE: nothing may reach memory.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h15; req_wdata = 32'h77;
    n = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
    end while (!mem_WE && n < 6);
    check("rst_mid_reached_write", 32'(mem_WE), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_WE), 32'd0);
    check("rst_mid_addr", mem_A, 32'd0);
    check("rst_mid_wd", mem_WD, 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_mem", mem[5], ref_mem[5]);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(MEM_WORDS * 4, MEM_WORDS * 4 + 64)
                                      : $urandom_range(0, MEM_WORDS * 4 - 1);
      do_req(1'($urandom_range(0, 1)), f3_pool[$urandom_range(0, 7)], a, $urandom,
             int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < MEM_WORDS; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
